// File: rtl/flow_light_ctrl.sv
// -----------------------------------------------------------------------------
// flow_light_ctrl
// Sequencer for an 8-LED flowing-water light. A prescaler divides clk into a
// step tick whose period is DIV_BASE << (3 - speed) cycles. On each tick the
// 3-bit LED position steps left, right, bounces between the ends, or holds.
//
// Ports:
//   clk    in   system clock, rising-edge active
//   rst    in   asynchronous active-high reset
//   en     in   run enable (0 freezes prescaler and position)
//   mode   in   [1:0] 00 left, 01 right, 10 bounce, 11 hold
//   speed  in   [1:0] step period select, 3 is fastest
//   idx    out  [2:0] registered LED position (decoder input)
//   led    out  [7:0] registered one-hot of idx
//   step   out  one-cycle pulse per prescaler tick
//   wrap   out  one-cycle pulse when the pattern reaches an end
// -----------------------------------------------------------------------------
module flow_light_ctrl #(
    parameter int DIV_BASE = 25_000_000,
    parameter int DIV_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
    output logic [2:0] idx,
    output logic [7:0] led,
    output logic       step,
    output logic       wrap
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [DIV_W-1:0] BASE_C = DIV_W'(DIV_BASE);
    localparam logic [DIV_W-1:0] ONE_C  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] ZERO_C = {DIV_W{1'b0}};

    // One-hot decode of a 3-bit position.
    function automatic logic [7:0] onehot8(input logic [2:0] pos);
        onehot8 = 8'h01 << pos;
    endfunction

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nx_s;
    logic [DIV_W-1:0] period_s;
    logic [DIV_W-1:0] period_m1_s;
    logic [1:0]       shift_s;
    logic             tick_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nx_s;
    logic [7:0]       led_r;
    logic             step_r;
    logic             wrap_r;
    logic             wrap_nx_s;
    dir_t             dir_r;
    dir_t             dir_nx_s;

    // Step period follows speed combinationally, so a speed change takes
    // effect on the very next cycle; ">=" lets a shortened period fire at once.
    always_comb begin
        shift_s     = 2'd3 - speed;
        period_s    = BASE_C << shift_s;
        period_m1_s = period_s - ONE_C;
        tick_s      = en && (cnt_r >= period_m1_s);
    end

    // Next-state logic for prescaler, position, direction and wrap pulse.
    always_comb begin
        cnt_nx_s  = cnt_r;
        idx_nx_s  = idx_r;
        dir_nx_s  = dir_r;
        wrap_nx_s = 1'b0;
        if (tick_s) begin
            cnt_nx_s = ZERO_C;
            case (mode)
                2'b00: begin
                    idx_nx_s  = idx_r + 3'd1;
                    wrap_nx_s = (idx_r == 3'd7);
                end
                2'b01: begin
                    idx_nx_s  = idx_r - 3'd1;
                    wrap_nx_s = (idx_r == 3'd0);
                end
                2'b10: begin
                    case (dir_r)
                        DIR_UP: begin
                            // Entering bounce parked at the top end: turn
                            // around rather than repeat the endpoint.
                            if (idx_r == 3'd7) begin
                                idx_nx_s = 3'd6;
                                dir_nx_s = DIR_DOWN;
                            end else begin
                                idx_nx_s = idx_r + 3'd1;
                                if (idx_r == 3'd6) begin
                                    dir_nx_s  = DIR_DOWN;
                                    wrap_nx_s = 1'b1;
                                end else begin
                                    dir_nx_s  = DIR_UP;
                                end
                            end
                        end
                        DIR_DOWN: begin
                            if (idx_r == 3'd0) begin
                                idx_nx_s = 3'd1;
                                dir_nx_s = DIR_UP;
                            end else begin
                                idx_nx_s = idx_r - 3'd1;
                                if (idx_r == 3'd1) begin
                                    dir_nx_s  = DIR_UP;
                                    wrap_nx_s = 1'b1;
                                end else begin
                                    dir_nx_s  = DIR_DOWN;
                                end
                            end
                        end
                        default: begin
                            dir_nx_s = DIR_UP;
                        end
                    endcase
                end
                default: begin
                    idx_nx_s = idx_r;
                end
            endcase
        end else if (en) begin
            cnt_nx_s = cnt_r + ONE_C;
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // State and output registers; led is decoded from the next index so it
    // changes on the same edge as idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= ZERO_C;
            idx_r  <= 3'd0;
            led_r  <= 8'h01;
            step_r <= 1'b0;
            wrap_r <= 1'b0;
            dir_r  <= DIR_UP;
        end else begin
            cnt_r  <= cnt_nx_s;
            idx_r  <= idx_nx_s;
            led_r  <= onehot8(idx_nx_s);
            step_r <= tick_s;
            wrap_r <= wrap_nx_s;
            dir_r  <= dir_nx_s;
        end
    end

    assign idx  = idx_r;
    assign led  = led_r;
    assign step = step_r;
    assign wrap = wrap_r;

endmodule
